// File: rtl/commit_trace_tx.sv
// commit_trace_tx: turns per-cycle commit events (register writes, loads,
// stores) into a stream of trace records through an 8-entry FIFO. After
// halt it drains the FIFO and then emits a fixed summary of performance
// counters followed by an END record.
//
// Record handshake: a record moves on a rising clk edge when rec_valid and
// rec_ready are both 1. While rec_valid is 1 and rec_ready is 0, the record
// (rec_type, rec_a, rec_b) holds steady. rec_valid never depends on
// rec_ready.
//
// The FSM state is kept in the signal 'state' (RUN, DRAIN, SUMMARY, DONE)
// so checkers can bind to it by name.
module commit_trace_tx (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_write,
    input  logic [2:0]  write_reg,
    input  logic [15:0] write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_data_in,
    input  logic [15:0] mem_data_out,
    input  logic        halt,
    input  logic        icache_req,
    input  logic        icache_hit,
    input  logic        dcache_req,
    input  logic        dcache_hit,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [3:0]  rec_type,
    output logic [15:0] rec_a,
    output logic [15:0] rec_b,
    output logic        overflow,
    output logic        done
);

    localparam logic [1:0] stRun     = 2'd0;
    localparam logic [1:0] stDrain   = 2'd1;
    localparam logic [1:0] stSummary = 2'd2;
    localparam logic [1:0] stDone    = 2'd3;

    localparam logic [3:0] typeReg   = 4'd1;
    localparam logic [3:0] typeLoad  = 4'd2;
    localparam logic [3:0] typeStore = 4'd3;
    localparam logic [3:0] typeCyc   = 4'd8;
    localparam logic [3:0] typeInst  = 4'd9;
    localparam logic [3:0] typeDhit  = 4'd10;
    localparam logic [3:0] typeIhit  = 4'd11;
    localparam logic [3:0] typeDreq  = 4'd12;
    localparam logic [3:0] typeIreq  = 4'd13;
    localparam logic [3:0] typeEnd   = 4'd15;

    localparam logic [2:0] lastSumIdx = 3'd6;

    // A record is {type[3:0], a[15:0], b[15:0]}.
    logic [1:0]  state;
    logic [35:0] fifoMem [0:7];
    logic [2:0]  wrPtr;
    logic [2:0]  rdPtr;
    logic [3:0]  fifoCount;
    logic [2:0]  sumIdx;
    logic        overflowReg;

    logic [31:0] cycCnt;
    logic [31:0] instCnt;
    logic [31:0] dhitCnt;
    logic [31:0] ihitCnt;
    logic [31:0] dreqCnt;
    logic [31:0] ireqCnt;

    logic        inRun;
    logic        fifoMode;
    logic [1:0]  evNum;
    logic [35:0] evRec0;
    logic [35:0] evRec1;
    logic [35:0] evRec2;
    logic [3:0]  freeSlots;
    logic        doPush;
    logic        doDrop;
    logic        doPop;
    logic [35:0] sumRec;
    logic [35:0] outRec;

    function automatic logic [31:0] satInc(input logic [31:0] v, input logic en);
        if (en && (v != 32'hFFFF_FFFF)) begin
            return v + 32'd1;
        end
        return v;
    endfunction

    assign inRun     = (state == stRun);
    assign fifoMode  = (state == stRun) || (state == stDrain);
    assign evNum     = {1'b0, reg_write} + {1'b0, mem_read} + {1'b0, mem_write};
    // Free slots are taken from the registered count, before any pop this cycle.
    assign freeSlots = 4'd8 - fifoCount;
    assign doPush    = inRun && (evNum != 2'd0) && (freeSlots >= {2'b00, evNum});
    assign doDrop    = inRun && (evNum != 2'd0) && !doPush;
    assign doPop     = fifoMode && (fifoCount != 4'd0) && rec_ready;

    // Pack this cycle's events densely in REG, LOAD, STORE order.
    always_comb begin
        evRec0 = '0;
        evRec1 = '0;
        evRec2 = '0;
        if (reg_write) begin
            evRec0 = {typeReg, 13'd0, write_reg, write_data};
        end else if (mem_read) begin
            evRec0 = {typeLoad, mem_addr, mem_data_out};
        end else begin
            evRec0 = {typeStore, mem_addr, mem_data_in};
        end
        if (reg_write && mem_read) begin
            evRec1 = {typeLoad, mem_addr, mem_data_out};
        end else begin
            evRec1 = {typeStore, mem_addr, mem_data_in};
        end
        evRec2 = {typeStore, mem_addr, mem_data_in};
    end

    // FIFO storage; contents need no reset because outputs are gated by occupancy.
    always_ff @(posedge clk) begin
        if (doPush) begin
            fifoMem[wrPtr] <= evRec0;
            if (evNum >= 2'd2) begin
                fifoMem[wrPtr + 3'd1] <= evRec1;
            end
            if (evNum == 2'd3) begin
                fifoMem[wrPtr + 3'd2] <= evRec2;
            end
        end
    end

    // FIFO pointers and occupancy; a cycle's events are pushed all together or not at all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr     <= 3'd0;
            rdPtr     <= 3'd0;
            fifoCount <= 4'd0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + {1'b0, evNum};
            end
            if (doPop) begin
                rdPtr <= rdPtr + 3'd1;
            end
            fifoCount <= fifoCount + (doPush ? {2'b00, evNum} : 4'd0) - (doPop ? 4'd1 : 4'd0);
        end
    end

    // Sticky overflow flag: set whenever a whole cycle of events is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflowReg <= 1'b0;
        end else if (doDrop) begin
            overflowReg <= 1'b1;
        end
    end

    // Saturating performance counters, live only in RUN (halt cycle included).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycCnt  <= 32'd0;
            instCnt <= 32'd0;
            dhitCnt <= 32'd0;
            ihitCnt <= 32'd0;
            dreqCnt <= 32'd0;
            ireqCnt <= 32'd0;
        end else if (inRun) begin
            cycCnt  <= satInc(cycCnt, 1'b1);
            instCnt <= satInc(instCnt, halt | reg_write | mem_write);
            dhitCnt <= satInc(dhitCnt, dcache_hit);
            ihitCnt <= satInc(ihitCnt, icache_hit);
            dreqCnt <= satInc(dreqCnt, dcache_req);
            ireqCnt <= satInc(ireqCnt, icache_req);
        end
    end

    // Phase sequencing: RUN until halt, DRAIN until empty, SUMMARY until END transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= stRun;
            sumIdx <= 3'd0;
        end else begin
            case (state)
                stRun: begin
                    if (halt) begin
                        state <= stDrain;
                    end
                end
                stDrain: begin
                    if (fifoCount == 4'd0) begin
                        state  <= stSummary;
                        sumIdx <= 3'd0;
                    end
                end
                stSummary: begin
                    if (rec_ready) begin
                        if (sumIdx == lastSumIdx) begin
                            state <= stDone;
                        end else begin
                            sumIdx <= sumIdx + 3'd1;
                        end
                    end
                end
                default: begin
                    state <= stDone;
                end
            endcase
        end
    end

    // Summary record selected by position in the fixed CYC..END sequence.
    always_comb begin
        sumRec = {typeEnd, 32'd0};
        case (sumIdx)
            3'd0:    sumRec = {typeCyc,  cycCnt};
            3'd1:    sumRec = {typeInst, instCnt};
            3'd2:    sumRec = {typeDhit, dhitCnt};
            3'd3:    sumRec = {typeIhit, ihitCnt};
            3'd4:    sumRec = {typeDreq, dreqCnt};
            3'd5:    sumRec = {typeIreq, ireqCnt};
            default: sumRec = {typeEnd, 32'd0};
        endcase
    end

    // Output mux: FIFO head in RUN/DRAIN, summary record in SUMMARY, all zero otherwise.
    always_comb begin
        rec_valid = 1'b0;
        outRec    = '0;
        case (state)
            stRun, stDrain: begin
                if (fifoCount != 4'd0) begin
                    rec_valid = 1'b1;
                    outRec    = fifoMem[rdPtr];
                end
            end
            stSummary: begin
                rec_valid = 1'b1;
                outRec    = sumRec;
            end
            default: begin
                rec_valid = 1'b0;
                outRec    = '0;
            end
        endcase
    end

    assign rec_type = outRec[35:32];
    assign rec_a    = outRec[31:16];
    assign rec_b    = outRec[15:0];
    assign overflow = overflowReg;
    assign done     = (state == stDone);

endmodule

// File: tb/tb_commit_trace_tx.sv
// Testbench for commit_trace_tx: directed scenarios, a queue-based model of
// the record stream checked every cycle, and literal expectations for the
// key scenarios.
module tb_commit_trace_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reg_write;
    logic [2:0]  write_reg;
    logic [15:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;
    logic        halt;
    logic        icache_req;
    logic        icache_hit;
    logic        dcache_req;
    logic        dcache_hit;
    logic        rec_valid;
    logic        rec_ready = 1'b0;
    logic [3:0]  rec_type;
    logic [15:0] rec_a;
    logic [15:0] rec_b;
    logic        overflow;
    logic        done;

    commit_trace_tx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .reg_write    (reg_write),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .halt         (halt),
        .icache_req   (icache_req),
        .icache_hit   (icache_hit),
        .dcache_req   (dcache_req),
        .dcache_hit   (dcache_hit),
        .rec_valid    (rec_valid),
        .rec_ready    (rec_ready),
        .rec_type     (rec_type),
        .rec_a        (rec_a),
        .rec_b        (rec_b),
        .overflow     (overflow),
        .done         (done)
    );

    // Clock
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model: pending event records, phase (0 run, 1 drain, 2 summary, 3 done),
    // summary position, counters (cyc, inst, dhit, ihit, dreq, ireq), overflow.
    logic [35:0] exp_q[$];
    logic [35:0] gotQ[$];
    logic [35:0] wantQ[$];
    logic [35:0] evQ[$];
    int          phase = 0;
    int          sIdx = 0;
    logic [31:0] mCnt [6];
    logic        mOvf = 1'b0;
    int          preSize;
    int          freeSlots;
    logic        mValid;
    logic [35:0] mRec;

    function automatic logic [35:0] mk(input logic [3:0] t, input logic [15:0] a, input logic [15:0] b);
        return {t, a, b};
    endfunction

    function automatic logic [31:0] sat(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

    function automatic logic [35:0] sumRec(input int idx);
        if (idx >= 6) return {4'hF, 32'd0};
        return {4'(8 + idx), mCnt[idx]};
    endfunction

    task automatic check(input string nm, input logic [35:0] act, input logic [35:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model update on each clock edge; reset clears it like the hardware.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            phase = 0;
            sIdx = 0;
            mOvf = 1'b0;
            for (int i = 0; i < 6; i++) mCnt[i] = 32'd0;
        end else begin
            preSize = exp_q.size();
            if ((phase == 0 || phase == 1) && preSize > 0 && rec_ready) void'(exp_q.pop_front());
            if (phase == 0) begin
                freeSlots = 8 - preSize;
                evQ.delete();
                if (reg_write) evQ.push_back(mk(4'd1, {13'd0, write_reg}, write_data));
                if (mem_read)  evQ.push_back(mk(4'd2, mem_addr, mem_data_out));
                if (mem_write) evQ.push_back(mk(4'd3, mem_addr, mem_data_in));
                if (evQ.size() > 0) begin
                    if (freeSlots >= evQ.size()) begin
                        foreach (evQ[i]) exp_q.push_back(evQ[i]);
                    end else begin
                        mOvf = 1'b1;
                    end
                end
                mCnt[0] = sat(mCnt[0], 1'b1);
                mCnt[1] = sat(mCnt[1], halt | reg_write | mem_write);
                mCnt[2] = sat(mCnt[2], dcache_hit);
                mCnt[3] = sat(mCnt[3], icache_hit);
                mCnt[4] = sat(mCnt[4], dcache_req);
                mCnt[5] = sat(mCnt[5], icache_req);
                if (halt) phase = 1;
            end else if (phase == 1) begin
                if (preSize == 0) begin
                    phase = 2;
                    sIdx = 0;
                end
            end else if (phase == 2) begin
                if (rec_ready) begin
                    if (sIdx == 6) phase = 3;
                    else sIdx++;
                end
            end
        end
    end

    // Scoreboard compare on the falling edge, plus a log of every transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            mValid = ((phase == 0 || phase == 1) && exp_q.size() > 0) || phase == 2;
            mRec = (phase == 2) ? sumRec(sIdx) : ((exp_q.size() > 0) ? exp_q[0] : 36'd0);
            check("rec_valid", rec_valid, mValid);
            if (mValid) check("record", {rec_type, rec_a, rec_b}, mRec);
            check("done", done, phase == 3);
            check("overflow", overflow, mOvf);
            if (rec_valid && rec_ready) gotQ.push_back({rec_type, rec_a, rec_b});
        end
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clearIn();
        reg_write = 1'b0; write_reg = 3'd0; write_data = 16'd0;
        mem_read = 1'b0; mem_write = 1'b0; mem_addr = 16'd0;
        mem_data_in = 16'd0; mem_data_out = 16'd0; halt = 1'b0;
        icache_req = 1'b0; icache_hit = 1'b0; dcache_req = 1'b0; dcache_hit = 1'b0;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        clearIn();
        rec_ready = 1'b0;
        tick(2);
        gotQ.delete();
        rst_n = 1'b1;
    endtask

    task automatic waitDone(input string nm, input int limit);
        int k = 0;
        while (!done && k < limit) begin
            tick(1);
            k++;
        end
        check(nm, done, 1'b1);
    endtask

    task automatic checkLog(input string nm);
        check({nm, " count"}, 36'(gotQ.size()), 36'(wantQ.size()));
        for (int i = 0; i < wantQ.size() && i < gotQ.size(); i++) check(nm, gotQ[i], wantQ[i]);
    endtask

    task automatic pushSummary(input logic [31:0] cyc, input logic [31:0] inst,
                               input logic [31:0] dh, input logic [31:0] ih,
                               input logic [31:0] dr, input logic [31:0] ir);
        wantQ.push_back({4'd8, cyc});
        wantQ.push_back({4'd9, inst});
        wantQ.push_back({4'd10, dh});
        wantQ.push_back({4'd11, ih});
        wantQ.push_back({4'd12, dr});
        wantQ.push_back({4'd13, ir});
        wantQ.push_back({4'd15, 32'd0});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        clearIn();
        rec_ready = 1'b0;
        tick(2);
        // Reset state
        check("reset rec_valid", rec_valid, 1'b0);
        check("reset record", {rec_type, rec_a, rec_b}, 36'd0);
        check("reset overflow", overflow, 1'b0);
        check("reset done", done, 1'b0);
        rst_n = 1'b1;

        // Single register write
        rec_ready = 1'b1;
        reg_write = 1'b1; write_reg = 3'd3; write_data = 16'h1234;
        tick(1);
        clearIn();
        check("reg rec_valid", rec_valid, 1'b1);
        check("reg record", {rec_type, rec_a, rec_b}, mk(4'd1, 16'h0003, 16'h1234));
        tick(1);
        check("reg held one cycle", rec_valid, 1'b0);
        wantQ.delete();
        wantQ.push_back(mk(4'd1, 16'h0003, 16'h1234));
        checkLog("reg log");
        gotQ.delete();

        // Register write and store in the same cycle
        reg_write = 1'b1; write_reg = 3'd1; write_data = 16'h00AA;
        mem_write = 1'b1; mem_addr = 16'h0040; mem_data_in = 16'hBEEF;
        tick(1);
        clearIn();
        tick(4);
        wantQ.delete();
        wantQ.push_back(mk(4'd1, 16'h0001, 16'h00AA));
        wantQ.push_back(mk(4'd3, 16'h0040, 16'hBEEF));
        checkLog("reg+store log");
        gotQ.delete();

        // Backpressure: third 3-event cycle does not fit and is dropped
        rec_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            reg_write = 1'b1; write_reg = 3'd2; write_data = 16'h1000 + 16'(i);
            mem_read = 1'b1; mem_addr = 16'h2000 + 16'(i); mem_data_out = 16'h3000 + 16'(i);
            mem_write = 1'b1; mem_data_in = 16'h5000 + 16'(i);
            tick(1);
        end
        clearIn();
        check("overflow set", overflow, 1'b1);
        rec_ready = 1'b1;
        tick(12);
        wantQ.delete();
        for (int i = 0; i < 2; i++) begin
            wantQ.push_back(mk(4'd1, 16'h0002, 16'h1000 + 16'(i)));
            wantQ.push_back(mk(4'd2, 16'h2000 + 16'(i), 16'h3000 + 16'(i)));
            wantQ.push_back(mk(4'd3, 16'h2000 + 16'(i), 16'h5000 + 16'(i)));
        end
        checkLog("overflow drain log");
        applyReset();
        check("overflow cleared by reset", overflow, 1'b0);

        // Stalled load record stays stable, then moves exactly once
        mem_read = 1'b1; mem_addr = 16'h0100; mem_data_out = 16'h5A5A;
        tick(1);
        clearIn();
        for (int i = 0; i < 5; i++) begin
            check("stall valid", rec_valid, 1'b1);
            check("stall record", {rec_type, rec_a, rec_b}, mk(4'd2, 16'h0100, 16'h5A5A));
            tick(1);
        end
        rec_ready = 1'b1;
        tick(1);
        check("stall one transfer", 36'(gotQ.size()), 36'd1);
        tick(3);
        check("stall empty after", rec_valid, 1'b0);
        wantQ.delete();
        wantQ.push_back(mk(4'd2, 16'h0100, 16'h5A5A));
        checkLog("stall log");

        // Halt after 10 cycles with 4 register writes; inputs ignored afterwards
        applyReset();
        rec_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            clearIn();
            if (i < 4) begin
                reg_write = 1'b1; write_reg = 3'(i); write_data = 16'h0A00 + 16'(i);
            end
            if (i == 9) halt = 1'b1;
            tick(1);
        end
        clearIn();
        reg_write = 1'b1; write_reg = 3'd7; write_data = 16'hFFFF;
        mem_write = 1'b1; dcache_hit = 1'b1; icache_req = 1'b1;
        waitDone("summary reaches done", 40);
        clearIn();
        wantQ.delete();
        for (int i = 0; i < 4; i++) wantQ.push_back(mk(4'd1, 16'(i), 16'h0A00 + 16'(i)));
        pushSummary(32'd10, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0);
        checkLog("halt summary log");
        check("done rec_valid", rec_valid, 1'b0);
        tick(3);
        check("done sticky", done, 1'b1);
        check("done rec_valid later", rec_valid, 1'b0);

        // Cache strobes with irregular ready, then summary counts
        applyReset();
        for (int i = 0; i < 12; i++) begin
            clearIn();
            rec_ready = 1'($urandom_range(0, 1));
            icache_req = 1'b1;
            icache_hit = (i % 3) != 0;
            dcache_req = (i % 2) == 1;
            dcache_hit = (i % 4) == 0;
            if (i % 2 == 0) begin
                reg_write = 1'b1; write_reg = 3'd6; write_data = 16'(i);
            end
            if (i % 5 == 0) begin
                mem_read = 1'b1; mem_addr = 16'h0800 + 16'(i); mem_data_out = 16'(i * 3);
            end
            if (i == 11) halt = 1'b1;
            tick(1);
        end
        clearIn();
        rec_ready = 1'b1;
        waitDone("strobe run done", 60);
        wantQ.delete();
        pushSummary(32'd12, 32'd7, 32'd3, 32'd8, 32'd6, 32'd12);
        check("strobe log length", 36'(gotQ.size() >= 7), 36'd1);
        if (gotQ.size() >= 7) begin
            for (int i = 0; i < 7; i++) check("strobe summary", gotQ[gotQ.size() - 7 + i], wantQ[i]);
        end

        // Reset in the middle of SUMMARY while stalled
        applyReset();
        rec_ready = 1'b1;
        reg_write = 1'b1; write_reg = 3'd2; write_data = 16'h1111;
        tick(1);
        write_reg = 3'd4; write_data = 16'h2222;
        tick(1);
        clearIn();
        halt = 1'b1;
        tick(1);
        halt = 1'b0;
        k = 0;
        while (phase != 2 && k < 20) begin
            tick(1);
            k++;
        end
        rec_ready = 1'b0;
        check("summary reached", 36'(k < 20), 36'd1);
        check("summary first record", {rec_type, rec_a, rec_b}, mk(4'd8, 16'h0000, 16'h0003));
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset rec_valid", rec_valid, 1'b0);
        check("async reset record", {rec_type, rec_a, rec_b}, 36'd0);
        check("async reset done", done, 1'b0);
        check("async reset overflow", overflow, 1'b0);
        tick(1);
        gotQ.delete();
        rst_n = 1'b1;
        rec_ready = 1'b1;
        reg_write = 1'b1; write_reg = 3'd5; write_data = 16'h7777;
        tick(1);
        clearIn();
        halt = 1'b1;
        tick(1);
        halt = 1'b0;
        waitDone("post reset done", 40);
        wantQ.delete();
        wantQ.push_back(mk(4'd1, 16'h0005, 16'h7777));
        pushSummary(32'd2, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0);
        checkLog("post reset log");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/commit_trace_tx.md
COMMIT_TRACE_TX -- requirements
Module: commit_trace_tx

Interface
REQ-001 The block SHALL have these ports; reset is asynchronous and active-low:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  async active-low reset
- reg_write  in  1  register file written this cycle
- write_reg  in  3  destination register
- write_data  in  16  data written to register
- mem_read  in  1  memory read this cycle
- mem_write  in  1  memory write this cycle
- mem_addr  in  16  memory address
- mem_data_in  in  16  store data
- mem_data_out  in  16  load data
- halt  in  1  halt reached MEM/WB
- icache_req, icache_hit, dcache_req, dcache_hit  in  1 each  cache event strobes
- rec_valid  out  1  record available
- rec_ready  in  1  consumer accepts record
- rec_type  out  4  record type
- rec_a  out  16  payload word A
- rec_b  out  16  payload word B
- overflow  out  1  sticky: events were dropped
- done  out  1  summary complete

Function
REQ-002 Event record types SHALL be REG=1 (a={13'b0,write_reg}, b=write_data), LOAD=2 (a=mem_addr, b=mem_data_out), STORE=3 (a=mem_addr, b=mem_data_in).
REQ-003 Summary record types SHALL be CYC=8, INST=9, DHIT=10, IHIT=11, DREQ=12, IREQ=13 (a=count[31:16], b=count[15:0]) and END=15 (a=0, b=0).
REQ-004 In RUN, each cycle the block SHALL form up to 3 events in the fixed order REG, LOAD, STORE (mem_read and mem_write both high produce both).
REQ-005 Events SHALL enter an 8-entry FIFO in order; all events of a cycle are pushed only if free slots, sampled before any same-cycle pop, are >= the number of events.
REQ-006 If free slots are insufficient, all events of that cycle SHALL be dropped and overflow set until reset; the block never partially pushes a cycle.
REQ-007 A record transfers on a rising edge with rec_valid=1 and rec_ready=1; while rec_valid=1 and rec_ready=0, rec_type/rec_a/rec_b SHALL hold stable.
REQ-008 rec_valid SHALL be 1 in RUN/DRAIN whenever the FIFO is non-empty, and the FIFO head SHALL drive the record outputs.
REQ-009 32-bit counters SHALL saturate at 0xFFFFFFFF: cycles (+1 every RUN cycle including the halt cycle), inst (+1 when halt|reg_write|mem_write), dhit, ihit, dreq, ireq (+1 per strobe high).
REQ-010 States SHALL be RUN, DRAIN, SUMMARY, DONE. RUN->DRAIN on halt=1; the halt cycle's events and counts are processed normally.
REQ-011 In DRAIN, SUMMARY and DONE, all event and counter inputs SHALL be ignored and counters frozen.
REQ-012 DRAIN->SUMMARY when the FIFO is empty (including the cycle after the final pop).
REQ-013 SUMMARY SHALL present CYC, INST, DHIT, IHIT, DREQ, IREQ, END in order, bypassing the FIFO, advancing one record per transfer; after END transfers, the block enters DONE.
REQ-014 In DONE, rec_valid SHALL be 0 and done SHALL be 1 until reset.
REQ-015 The event FIFO SHALL use 3-bit read/write pointers that wrap modulo 8 and a 4-bit occupancy count 0..8.

Reset
REQ-016 Assertion of rst_n=0 SHALL immediately, mid-operation included, force state RUN, the FIFO empty, all counters 0, and overflow, done, rec_valid, rec_type, rec_a and rec_b all 0.
REQ-017 In-flight records SHALL be discarded on reset without any transfer.

Verification
REQ-018 Reg write r3=0x1234 with rec_ready=1 -> next cycle rec_valid=1, type 1, a=0x0003, b=0x1234, held for one cycle.
REQ-019 reg_write plus mem_write in one cycle (r1=0x00AA; addr 0x0040, data 0xBEEF) -> REG then STORE {0x0040,0xBEEF}, in order.
REQ-020 rec_ready=0 with 3 events per cycle for 3 cycles -> FIFO holds 6, third cycle dropped, overflow=1; after rec_ready=1, exactly 6 records drain.
REQ-021 Halt after 10 cycles with 4 reg writes, rec_ready=1 -> records CYC {0,10}, INST {0,5}, zero cache counts, END, then done=1 and rec_valid=0.
REQ-022 rst_n pulsed low during SUMMARY with rec_ready=0 -> outputs 0 asynchronously; after release, state RUN and counters restart from 0.
REQ-023 Stall rec_ready=0 for 5 cycles on a LOAD record -> payload stable throughout; exactly one transfer on release.
